feedback_sequencer: RTL
=======================

FEEDBACK_SEQUENCER -- requirements
Module: feedback_sequencer

Interface
REQ-001 The block SHALL have these parameters: CW, 4, bits per colour channel.
REQ-002 The block SHALL have parameter BLINK_HALF, 500, clock cycles per blink half-period.
REQ-003 The block SHALL have parameter BEEP_LEN, 250, cycles per beep.
REQ-004 The block SHALL have parameter GAP_LEN, 250, cycles of silence between beeps.
REQ-005 The block SHALL have parameter FAIL_BEEPS, 3, beep count for FAIL (range 1..15).
REQ-006 The block SHALL have parameter HI_HALF, 1, tone half-period in cycles for the success tone.
REQ-007 The block SHALL have parameter LO_HALF, 4, tone half-period in cycles for the fail and alarm tone.
REQ-008 The block SHALL have parameter BRIGHT, 16, LED duty in sixteenths (range 0..16).
REQ-009 The block SHALL have these ports: clk_1khz, input, 1, the only clock; all logic on the rising edge.
REQ-010 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-011 The block SHALL have port state, input, 4; safe state code. SUCCESS=4'b0111, FAIL=4'b1000, DEACTIVATE=4'b1001, EMERGENCY=4'b1010, all other codes are quiet.
REQ-012 The block SHALL have port rgb_out, output, 3*CW; {R,G,B}, registered.
REQ-013 The block SHALL have port piezo_pwm, output, 1; registered square-wave tone.
REQ-014 The block SHALL have port busy, output, 1; high while the piezo FSM is not IDLE.

Function
REQ-015 The block SHALL register state into prev_state every cycle; entry SHALL be asserted when state != prev_state.
REQ-016 Blink: counter SHALL run 0..BLINK_HALF-1; blink SHALL toggle on wrap. On entry to DEACTIVATE or EMERGENCY, the counter SHALL clear to 0 and blink SHALL be set to 1.
REQ-017 rgb_out SHALL be updated one cycle after state, with FULL meaning all-ones of CW:
- SUCCESS: {0,FULL,0}.
- FAIL: {FULL,0,0}.
- EMERGENCY: {FULL,FULL,0} when blink=1, else 0.
- DEACTIVATE: {FULL,0,0} when blink=1, else 0.
- Any other code: 0.
REQ-018 Piezo FSM states SHALL be IDLE, TONE, GAP and ALARM.
REQ-019 Entry to SUCCESS SHALL go to TONE with tone=HI_HALF and beeps_left=1.
REQ-020 Entry to FAIL SHALL go to TONE with tone=LO_HALF and beeps_left=FAIL_BEEPS.
REQ-021 Entry to DEACTIVATE or EMERGENCY SHALL go to ALARM; entry to any other code SHALL go to IDLE.
REQ-022 TONE SHALL last exactly BEEP_LEN cycles. After that, it SHALL go to GAP if beeps_left>1, else to IDLE.
REQ-023 GAP SHALL last exactly GAP_LEN cycles, decrement beeps_left, then return to TONE.
REQ-024 IDLE SHALL be reached after the last beep even if state holds SUCCESS/FAIL; the block SHALL NOT retrigger without a new entry.
REQ-025 ALARM SHALL sound the LO_HALF tone while blink=1 and mute while blink=0; it SHALL persist while state holds.
REQ-026 Entry during any FSM state SHALL abort the current sequence and apply REQ-019 to REQ-021 in the same cycle.
REQ-027 Tone generator: a half-period counter SHALL toggle piezo_pwm when it reaches half-1, then clear.
REQ-028 On every TONE start, and on the ALARM blink 0->1 transition, the tone counter and piezo_pwm SHALL clear to 0.
REQ-029 When muted (IDLE, GAP, ALARM with blink=0), piezo_pwm SHALL be 0 from the next cycle.
REQ-030 All counters SHALL be sized with $clog2 of their parameter and SHALL never wrap past their terminal value.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set: rgb_out=0, piezo_pwm=0, busy=0, FSM=IDLE, all counters=0, blink=0, prev_state=state.
REQ-032 Reset SHALL override any sequence in progress.
REQ-033 The first cycle after reset SHALL generate no entry event.

Configuration
REQ-034 The feature macro SHALL be FB_DIM_EN.
REQ-035 When FB_DIM_EN is defined: a free-running 4-bit dim counter (0..15) SHALL gate rgb_out to 0 whenever dim_cnt >= BRIGHT. BRIGHT=16 SHALL give full on; BRIGHT=0 SHALL give always off. The dim counter SHALL reset to 0.
REQ-036 When FB_DIM_EN is undefined: no dim logic SHALL exist, BRIGHT SHALL be ignored, and rgb_out SHALL follow REQ-017 exactly.

Verification
REQ-037 SUCCESS test: reset, then state 0000->0111. Required response:
- rgb_out=12'h0F0 one cycle later.
- piezo_pwm toggles every cycle for 250 cycles.
- busy high for 250 cycles, then piezo_pwm=0 while state held.
REQ-038 FAIL test: state ->1000. Required response:
- rgb_out=12'hF00.
- Three 250-cycle beeps at period 8 with 250-cycle gaps.
- busy high for 1250 cycles.
REQ-039 EMERGENCY test: state ->1010 held for 2000 cycles. Required response:
- rgb_out alternates 12'hFF0 / 12'h000 every 500 cycles, starting with FF0.
- piezo_pwm sounds only during the FF0 phases.
REQ-040 Abort test: FAIL entered, then after 400 cycles (during the gap) switched to SUCCESS. Required response:
- The high tone starts on the entry cycle.
- busy drops 250 cycles later.
- No further fail beeps.
REQ-041 Reset test: rst pulsed mid-DEACTIVATE with state held at 1001. Required response:
- All outputs 0 the next cycle.
- No alarm restart until state changes.
REQ-042 Dim test: FB_DIM_EN with BRIGHT=4 in SUCCESS. Required response: G=F for 4 of every 16 cycles, 0 otherwise.

Source files
------------

// File: rtl/feedback_sequencer.sv
// LED colour + piezo tone sequencer driven by a 4-bit safe-state code.
// Optional LED dimming is built when FB_DIM_EN is defined.
module feedback_sequencer #(
  parameter int unsigned CW         = 4,
  parameter int unsigned BLINK_HALF = 500,
  parameter int unsigned BEEP_LEN   = 250,
  parameter int unsigned GAP_LEN    = 250,
  parameter int unsigned FAIL_BEEPS = 3,
  parameter int unsigned HI_HALF    = 1,
  parameter int unsigned LO_HALF    = 4,
  parameter int unsigned BRIGHT     = 16
) (
  input  logic            clk_1khz,
  input  logic            rst,
  input  logic [3:0]      state,
  output logic [3*CW-1:0] rgb_out,
  output logic            piezo_pwm,
  output logic            busy
);

  localparam logic [3:0] ST_SUCCESS    = 4'b0111;
  localparam logic [3:0] ST_FAIL       = 4'b1000;
  localparam logic [3:0] ST_DEACTIVATE = 4'b1001;
  localparam logic [3:0] ST_EMERGENCY  = 4'b1010;

  localparam int unsigned BLINK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned BEAT_MAX = (BEEP_LEN > GAP_LEN) ? BEEP_LEN : GAP_LEN;
  localparam int unsigned BEAT_W   = (BEAT_MAX > 1) ? $clog2(BEAT_MAX) : 1;
  localparam int unsigned HALF_MAX = (HI_HALF > LO_HALF) ? HI_HALF : LO_HALF;
  localparam int unsigned TONE_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int unsigned BEEPS_W  = 4;

  // Elaboration-time range checks on the configuration
  if (FAIL_BEEPS < 1 || FAIL_BEEPS > 15) begin : g_bad_fail_beeps
    $error("feedback_sequencer: FAIL_BEEPS must be 1..15");
  end
  if (BRIGHT > 16) begin : g_bad_bright
    $error("feedback_sequencer: BRIGHT must be 0..16");
  end

  typedef enum logic [1:0] {
    PZ_IDLE  = 2'd0,
    PZ_TONE  = 2'd1,
    PZ_GAP   = 2'd2,
    PZ_ALARM = 2'd3
  } pz_state_t;

  pz_state_t            pz_state, pz_nxt;
  logic [3:0]           prev_state;
  logic [BLINK_W-1:0]   blink_cnt, blink_cnt_nxt;
  logic                 blink, blink_nxt;
  logic [BEAT_W-1:0]    beat_cnt, beat_nxt;
  logic [BEEPS_W-1:0]   beeps_left, beeps_nxt;
  logic                 tone_hi, tone_hi_nxt;
  logic [TONE_W-1:0]    tone_cnt, tone_cnt_nxt, half_m1;
  logic                 pwm_nxt;
  logic                 tone_clr;
  logic                 sound;
  logic                 entry_c;
  logic                 dim_off_c;
  logic [3*CW-1:0]      colour;
  logic [3*CW-1:0]      rgb_nxt;

  assign entry_c = (state != prev_state);

  // Blink timebase; restarts lit on alarm entry
  always_comb begin
    blink_cnt_nxt = blink_cnt + BLINK_W'(1);
    blink_nxt     = blink;
    if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_nxt = '0;
      blink_nxt     = ~blink;
    end
    if (entry_c && (state == ST_DEACTIVATE || state == ST_EMERGENCY)) begin
      blink_cnt_nxt = '0;
      blink_nxt     = 1'b1;
    end
  end

  // Piezo sequencer next state; an entry event overrides whatever is running
  always_comb begin
    pz_nxt      = pz_state;
    beat_nxt    = beat_cnt;
    beeps_nxt   = beeps_left;
    tone_hi_nxt = tone_hi;
    tone_clr    = 1'b0;
    if (entry_c) begin
      beat_nxt = '0;
      case (state)
        ST_SUCCESS: begin
          pz_nxt      = PZ_TONE;
          tone_hi_nxt = 1'b1;
          beeps_nxt   = BEEPS_W'(1);
          tone_clr    = 1'b1;
        end
        ST_FAIL: begin
          pz_nxt      = PZ_TONE;
          tone_hi_nxt = 1'b0;
          beeps_nxt   = BEEPS_W'(FAIL_BEEPS);
          tone_clr    = 1'b1;
        end
        ST_DEACTIVATE, ST_EMERGENCY: begin
          pz_nxt      = PZ_ALARM;
          tone_hi_nxt = 1'b0;
          beeps_nxt   = '0;
          tone_clr    = 1'b1;
        end
        default: begin
          pz_nxt    = PZ_IDLE;
          beeps_nxt = '0;
        end
      endcase
    end else begin
      case (pz_state)
        PZ_TONE: begin
          if (beat_cnt == BEAT_W'(BEEP_LEN - 1)) begin
            beat_nxt = '0;
            pz_nxt   = (beeps_left > BEEPS_W'(1)) ? PZ_GAP : PZ_IDLE;
          end else begin
            beat_nxt = beat_cnt + BEAT_W'(1);
          end
        end
        PZ_GAP: begin
          if (beat_cnt == BEAT_W'(GAP_LEN - 1)) begin
            beat_nxt  = '0;
            beeps_nxt = beeps_left - BEEPS_W'(1);
            pz_nxt    = PZ_TONE;
            tone_clr  = 1'b1;
          end else begin
            beat_nxt = beat_cnt + BEAT_W'(1);
          end
        end
        default: beat_nxt = '0;
      endcase
    end
  end

  // Square-wave generator; phase restarts on each beep and each alarm flash
  always_comb begin
    half_m1      = tone_hi_nxt ? TONE_W'(HI_HALF - 1) : TONE_W'(LO_HALF - 1);
    sound        = (pz_nxt == PZ_TONE) || ((pz_nxt == PZ_ALARM) && blink_nxt);
    tone_cnt_nxt = '0;
    pwm_nxt      = 1'b0;
    if (sound && !tone_clr && !(pz_state == PZ_ALARM && !blink && blink_nxt)) begin
      if (tone_cnt == half_m1) begin
        tone_cnt_nxt = '0;
        pwm_nxt      = ~piezo_pwm;
      end else begin
        tone_cnt_nxt = tone_cnt + TONE_W'(1);
        pwm_nxt      = piezo_pwm;
      end
    end
  end

  always_comb begin
    colour = '0;
    case (state)
      ST_SUCCESS:    colour = {{CW{1'b0}}, {CW{1'b1}}, {CW{1'b0}}};
      ST_FAIL:       colour = {{CW{1'b1}}, {CW{1'b0}}, {CW{1'b0}}};
      ST_EMERGENCY:  colour = blink_nxt ? {{CW{1'b1}}, {CW{1'b1}}, {CW{1'b0}}} : '0;
      ST_DEACTIVATE: colour = blink_nxt ? {{CW{1'b1}}, {CW{1'b0}}, {CW{1'b0}}} : '0;
      default:       colour = '0;
    endcase
    rgb_nxt = dim_off_c ? '0 : colour;
  end

`ifdef FB_DIM_EN
  logic [3:0] dim_cnt;

  // Free-running PWM phase for LED brightness
  always_ff @(posedge clk_1khz) begin
    if (rst) dim_cnt <= '0;
    else     dim_cnt <= dim_cnt + 4'd1;
  end

  assign dim_off_c = ({1'b0, dim_cnt} >= 5'(BRIGHT));
`else
  assign dim_off_c = 1'b0;
`endif

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      prev_state <= state;
      blink_cnt  <= '0;
      blink      <= 1'b0;
      pz_state   <= PZ_IDLE;
      beat_cnt   <= '0;
      beeps_left <= '0;
      tone_hi    <= 1'b0;
      tone_cnt   <= '0;
      piezo_pwm  <= 1'b0;
      busy       <= 1'b0;
      rgb_out    <= '0;
    end else begin
      prev_state <= state;
      blink_cnt  <= blink_cnt_nxt;
      blink      <= blink_nxt;
      pz_state   <= pz_nxt;
      beat_cnt   <= beat_nxt;
      beeps_left <= beeps_nxt;
      tone_hi    <= tone_hi_nxt;
      tone_cnt   <= tone_cnt_nxt;
      piezo_pwm  <= pwm_nxt;
      busy       <= (pz_nxt != PZ_IDLE);
      rgb_out    <= rgb_nxt;
    end
  end

endmodule
